// File: rtl/full_add_pkg.sv
// rtl/full_add_pkg.sv - shared widths and a reference sum helper for the registered full adder
package full_add_pkg;

    localparam int FULL_ADD_DEFAULT_WIDTH = 1;
    localparam int FULL_ADD_MAX_WIDTH     = 64;

    // Returns {cout, sum} for operands masked to 'width' bits; nothing above bit 'width' is kept.
    function automatic logic [FULL_ADD_MAX_WIDTH:0] full_add_ref(
        input logic [FULL_ADD_MAX_WIDTH-1:0] a,
        input logic [FULL_ADD_MAX_WIDTH-1:0] b,
        input logic                          cin,
        input int                            width
    );
        logic [FULL_ADD_MAX_WIDTH:0] mask;
        logic [FULL_ADD_MAX_WIDTH:0] total;
        mask  = ({{FULL_ADD_MAX_WIDTH{1'b0}}, 1'b1} << width) - 1'b1;
        total = ({1'b0, a} & mask) + ({1'b0, b} & mask)
              + {{FULL_ADD_MAX_WIDTH{1'b0}}, cin};
        return total & ((mask << 1) | 1'b1);
    endfunction

endpackage

// File: rtl/full_add_if.sv
// rtl/full_add_if.sv - operand/result bundle for full_add; ovf exists only with FULL_ADD_OVF_EN
interface full_add_if
    import full_add_pkg::*;
#(
    parameter int WIDTH = FULL_ADD_DEFAULT_WIDTH
) ();

    logic             in_valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef FULL_ADD_OVF_EN
    logic             ovf;
`endif

    modport master (
        output in_valid, a, b, cin,
`ifdef FULL_ADD_OVF_EN
        input  ovf,
`endif
        input  out_valid, sum, cout
    );

    modport slave (
        input  in_valid, a, b, cin,
`ifdef FULL_ADD_OVF_EN
        output ovf,
`endif
        output out_valid, sum, cout
    );

endinterface

// File: rtl/full_add_fa_cell.sv
// rtl/full_add_fa_cell.sv - combinational 1-bit full adder cell
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic co
);

    logic p;

    assign p  = a ^ b;
    assign s  = p ^ cin;
    assign co = (a & b) | (cin & p);

endmodule

// File: rtl/full_add.sv
// rtl/full_add.sv - registered ripple-carry adder built from fa_cell; FULL_ADD_OVF_EN adds a registered signed-overflow flag
module full_add
    import full_add_pkg::*;
#(
    parameter int WIDTH = FULL_ADD_DEFAULT_WIDTH
) (
    input  logic       clk,
    input  logic       rst,
    full_add_if.slave  bus
);

    if (WIDTH < 1 || WIDTH > FULL_ADD_MAX_WIDTH) begin : g_width_check
        $error("full_add: WIDTH out of range");
    end

    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum_comb;
    logic             out_valid_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;

    assign carry[0] = bus.cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        fa_cell u_cell (
            .a   (bus.a[i]),
            .b   (bus.b[i]),
            .cin (carry[i]),
            .s   (sum_comb[i]),
            .co  (carry[i+1])
        );
    end

    // Result registers only load on a valid input so they hold across idle cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
        end else begin
            out_valid_q <= bus.in_valid;
            if (bus.in_valid) begin
                sum_q  <= sum_comb;
                cout_q <= carry[WIDTH];
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;

`ifdef FULL_ADD_OVF_EN
    logic ovf_q;

    // Carry into and out of the sign bit differ exactly on two's-complement overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (bus.in_valid) begin
            ovf_q <= carry[WIDTH] ^ carry[WIDTH-1];
        end
    end

    assign bus.ovf = ovf_q;
`endif

endmodule

// File: tb/tb_full_add.sv
// tb/tb_full_add.sv - scoreboard bench for full_add at WIDTH=4 and WIDTH=1
module tb_full_add;

    typedef struct packed {
        logic [3:0] sum;
        logic       cout;
        logic       ovf;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst_q;

    int n_checks = 0;
    int n_fail   = 0;

    res_t q4[$];
    res_t q1[$];
    res_t held4 = '0;
    res_t held1 = '0;

    full_add_if #(.WIDTH(4)) bus4 ();
    full_add_if #(.WIDTH(1)) bus1 ();

    full_add #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
    full_add #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Unsigned and signed views of the operation, straight from the arithmetic definition.
    function automatic res_t model(input int w, input logic [3:0] a, input logic [3:0] b, input logic cin);
        res_t   r;
        longint mask, ua, ub, tot, sa, sb, st;
        mask   = (longint'(1) << w) - 1;
        ua     = longint'(a) & mask;
        ub     = longint'(b) & mask;
        tot    = ua + ub + longint'(cin);
        r.sum  = 4'(tot & mask);
        r.cout = ((tot >> w) != 0);
        sa     = (ua >= (longint'(1) << (w - 1))) ? ua - (longint'(1) << w) : ua;
        sb     = (ub >= (longint'(1) << (w - 1))) ? ub - (longint'(1) << w) : ub;
        st     = sa + sb + longint'(cin);
        r.ovf  = (st > (longint'(1) << (w - 1)) - 1) || (st < -(longint'(1) << (w - 1)));
        return r;
    endfunction

    always @(posedge clk) rst_q = rst;

    always @(negedge clk) begin
        res_t e;
        if (rst_q === 1'b1) begin
            check("rst_valid4", 64'(bus4.out_valid), 64'd0);
            check("rst_sum4", 64'(bus4.sum), 64'd0);
            check("rst_cout4", 64'(bus4.cout), 64'd0);
            held4 = '0;
        end else if (bus4.out_valid === 1'b1) begin
            if (q4.size() == 0) begin
                check("spurious_valid4", 64'd1, 64'd0);
            end else begin
                e = q4.pop_front();
                check("sum4", 64'(bus4.sum), 64'(e.sum));
                check("cout4", 64'(bus4.cout), 64'(e.cout));
`ifdef FULL_ADD_OVF_EN
                check("ovf4", 64'(bus4.ovf), 64'(e.ovf));
`endif
                held4 = e;
            end
        end else begin
            check("valid4", 64'(bus4.out_valid), 64'd0);
            check("hold_sum4", 64'(bus4.sum), 64'(held4.sum));
            check("hold_cout4", 64'(bus4.cout), 64'(held4.cout));
        end
    end

    always @(negedge clk) begin
        res_t e;
        if (rst_q === 1'b1) begin
            check("rst_valid1", 64'(bus1.out_valid), 64'd0);
            check("rst_sum1", 64'(bus1.sum), 64'd0);
            check("rst_cout1", 64'(bus1.cout), 64'd0);
            held1 = '0;
        end else if (bus1.out_valid === 1'b1) begin
            if (q1.size() == 0) begin
                check("spurious_valid1", 64'd1, 64'd0);
            end else begin
                e = q1.pop_front();
                check("sum1", 64'(bus1.sum), 64'(e.sum));
                check("cout1", 64'(bus1.cout), 64'(e.cout));
`ifdef FULL_ADD_OVF_EN
                check("ovf1", 64'(bus1.ovf), 64'(e.ovf));
`endif
                held1 = e;
            end
        end else begin
            check("valid1", 64'(bus1.out_valid), 64'd0);
            check("hold_sum1", 64'(bus1.sum), 64'(held1.sum));
            check("hold_cout1", 64'(bus1.cout), 64'(held1.cout));
        end
    end

    task automatic step(input logic v4, input logic [3:0] a4, input logic [3:0] b4, input logic c4,
                        input logic v1, input logic a1, input logic b1, input logic c1);
        bus4.in_valid = v4;
        bus4.a        = a4;
        bus4.b        = b4;
        bus4.cin      = c4;
        bus1.in_valid = v1;
        bus1.a        = a1;
        bus1.b        = b1;
        bus1.cin      = c1;
        if (!rst && v4) q4.push_back(model(4, a4, b4, c4));
        if (!rst && v1) q1.push_back(model(1, {3'b000, a1}, {3'b000, b1}, c1));
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] da [6];
        logic [3:0] db [6];
        logic       dc [6];
        logic [2:0] combo;
        da = '{4'b0100, 4'b1000, 4'd15, 4'd15, 4'd7, 4'd8};
        db = '{4'b1000, 4'b0101, 4'd0,  4'd15, 4'd1, 4'd8};
        dc = '{1'b0,    1'b0,    1'b1,  1'b1,  1'b0, 1'b0};

        rst = 1'b1;
        step(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 4'hF, 4'hF, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        step(1'b1, 4'hF, 4'hF, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        rst = 1'b0;
        step(1'b0, 4'hF, 4'hF, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        step(1'b0, 4'h3, 4'h5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Directed WIDTH=4 vectors back-to-back, with WIDTH=1 walking every a/b/cin combination.
        for (int i = 0; i < 8; i++) begin
            combo = 3'(i);
            if (i < 6) step(1'b1, da[i], db[i], dc[i], 1'b1, combo[2], combo[1], combo[0]);
            else       step(1'b1, 4'(i * 3), 4'(i), 1'b1, 1'b1, combo[2], combo[1], combo[0]);
        end

        step(1'b1, 4'd9, 4'd9, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++)
            step(1'b0, 4'($urandom), 4'($urandom), 1'($urandom), 1'b0, 1'($urandom), 1'($urandom), 1'($urandom));

        for (int i = 0; i < 200; i++)
            step(1'($urandom_range(0, 3) != 0), 4'($urandom), 4'($urandom), 1'($urandom),
                 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));

        step(1'b1, 4'd12, 4'd7, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        rst = 1'b1;
        step(1'b1, 4'd5, 4'd6, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        rst = 1'b0;
        step(1'b0, 4'd1, 4'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 4'd4, 4'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 4'd10, 4'd11, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        check("drain4", 64'(q4.size()), 64'd0);
        check("drain1", 64'(q1.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
